// File: rtl/ss_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit
// positions, the active-high hex glyph table and the blank output levels.
package ss_pkg;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Entry n is the active-high {g,f,e,d,c,b,a} pattern for hex value n.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic       DIGIT_OFF = 1'b1;

endpackage

// File: rtl/ss_mux_driver_if.sv
// Value/control inputs and active-low pin outputs of the seven-segment driver.
interface ss_mux_driver_if #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BRIGHT_W   = 4
);

   logic [4*NUM_DIGITS-1:0] Digits;
   logic [NUM_DIGITS-1:0]   DecimalPoints;
   logic [NUM_DIGITS-1:0]   DigitEnable;
   logic [BRIGHT_W-1:0]     Brightness;
   logic                    LeadingZeroBlank;
   logic [NUM_DIGITS-1:0]   SegmentDrivers;
   logic [7:0]              SevenSegment;
   logic                    FrameStart;

   modport master (
      output Digits, DecimalPoints, DigitEnable, Brightness, LeadingZeroBlank,
      input  SegmentDrivers, SevenSegment, FrameStart
   );

   modport slave (
      input  Digits, DecimalPoints, DigitEnable, Brightness, LeadingZeroBlank,
      output SegmentDrivers, SevenSegment, FrameStart
   );

endinterface

// File: rtl/ss_hex_decoder.sv
// Combinational 4-bit value to active-high {g,f,e,d,c,b,a} segment decoder.
module ss_hex_decoder
   import ss_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_GLYPH[val_i];

endmodule

// File: rtl/ss_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead-time, PWM
// brightness, per-digit enable/DP, leading-zero blanking and frame snapshots.
module ss_mux_driver
   import ss_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 8,
   parameter int unsigned PRESCALE_BITS = 17,
   parameter int unsigned BRIGHT_W      = 4,
   parameter int unsigned DEAD_CYCLES   = 64
) (
   input  logic           Clk,
   input  logic           Reset,
   ss_mux_driver_if.slave bus
);

   localparam int unsigned     IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [PRESCALE_BITS-1:0] count_q, count_d;
   logic [IDX_W-1:0]         index_q, index_d;
   logic [4*NUM_DIGITS-1:0]  digits_q, digits_d;
   logic [NUM_DIGITS-1:0]    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]    en_q, en_d;
   logic                     lzb_q, lzb_d;
   logic [NUM_DIGITS-1:0]    drv_q, drv_d;
   logic [7:0]               seg_q, seg_d;
   logic                     fs_q, fs_d;

   logic                  slot_end;
   logic                  frame_wrap;
   logic                  lit;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic [3:0]            cur_val;
   logic [6:0]            cur_glyph;

   assign slot_end   = &count_q;
   assign frame_wrap = slot_end && (index_q == LAST_IDX);

   always_comb begin
      count_d  = count_q + PRESCALE_BITS'(1);
      index_d  = index_q;
      digits_d = digits_q;
      dp_d     = dp_q;
      en_d     = en_q;
      lzb_d    = lzb_q;
      if (slot_end) begin
         index_d = frame_wrap ? '0 : index_q + IDX_W'(1);
      end
      // Inputs are only sampled at the frame wrap so a frame never tears.
      if (frame_wrap) begin
         digits_d = bus.Digits;
         dp_d     = bus.DecimalPoints;
         en_d     = bus.DigitEnable;
         lzb_d    = bus.LeadingZeroBlank;
      end
   end

   // Disabled digits keep the scan going, so they count as blank here.
   always_comb begin
      logic run;
      lz_mask = '0;
      run     = lzb_q;
      for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
         lz_mask[k] = run && (digits_q[4*k +: 4] == 4'h0) && !dp_q[k];
         run        = run && (lz_mask[k] || !en_q[k]);
      end
   end

   assign cur_val = digits_q[{index_q, 2'b00} +: 4];

   ss_hex_decoder u_hex_decoder (
      .val_i (cur_val),
      .seg_o (cur_glyph)
   );

   assign lit = (count_q >= PRESCALE_BITS'(DEAD_CYCLES))
             && (count_q[PRESCALE_BITS-1 -: BRIGHT_W] <= bus.Brightness)
             && en_q[index_q]
             && !lz_mask[index_q];

   always_comb begin
      drv_d = {NUM_DIGITS{DIGIT_OFF}};
      seg_d = SEG_OFF;
      fs_d  = frame_wrap;
      if (lit) begin
         drv_d[index_q] = ~DIGIT_OFF;
         seg_d          = ~{dp_q[index_q], cur_glyph};
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         count_q  <= '0;
         index_q  <= '0;
         digits_q <= '0;
         dp_q     <= '0;
         en_q     <= '0;
         lzb_q    <= 1'b0;
         drv_q    <= {NUM_DIGITS{DIGIT_OFF}};
         seg_q    <= SEG_OFF;
         fs_q     <= 1'b0;
      end else begin
         count_q  <= count_d;
         index_q  <= index_d;
         digits_q <= digits_d;
         dp_q     <= dp_d;
         en_q     <= en_d;
         lzb_q    <= lzb_d;
         drv_q    <= drv_d;
         seg_q    <= seg_d;
         fs_q     <= fs_d;
      end
   end

   assign bus.SegmentDrivers = drv_q;
   assign bus.SevenSegment   = seg_q;
   assign bus.FrameStart     = fs_q;

endmodule
